// File: rtl/sp_ram_clr.sv
// Single-port word RAM (TCM) with req/gnt handshake, byte-enabled writes,
// 1- or 2-cycle read latency and a word-per-cycle clear engine.
module sp_ram_clr #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WORDS      = 256,
  parameter int READ_LAT       = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic                    clear_i,
  output logic                    busy_o
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFS = $clog2(NB);
  localparam int IW   = ADDR_WIDTH - OFFS;
  localparam int AW   = $clog2(NUM_WORDS);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          clr_active;

  logic [IW-1:0] idx;
  logic          in_range;
  logic          acc;
  logic          acc_wr;
  logic          clr_wr;
  logic [AW-1:0] mem_addr;

  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] data1;

  logic                  valid1_reg;
  logic                  zero1_reg;
  logic                  merge1_reg;
  logic [NB-1:0]         be1_reg;
  logic [DATA_WIDTH-1:0] wdata1_reg;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_active = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clr_active = 1'b1;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == AW'(NUM_WORDS - 1)) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end
      end
      ST_READY: begin
        if (clear_i) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      default: state_next = ST_READY;
    endcase
  end

  assign busy_o = (state_reg == ST_CLEAR);
  // clear_i wins over a same-cycle request
  assign gnt_o  = req_i & (state_reg == ST_READY) & ~clear_i;
  assign acc    = gnt_o;

  assign idx = addr_i[ADDR_WIDTH-1:OFFS];

  generate
    if (IW > AW) begin : g_range
      assign in_range = ~|idx[IW-1:AW];
    end else begin : g_full
      assign in_range = 1'b1;
    end
    if (OFFS > 0) begin : g_offs
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^addr_i[OFFS-1:0];
    end
  endgenerate

  assign acc_wr   = acc & we_i & in_range;
  // A reset edge abandons the clear without writing another word
  assign clr_wr   = clr_active & ~rst_i;
  assign mem_addr = clr_active ? cnt_reg : idx[AW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [NUM_WORDS];
      logic [7:0] rd_byte_reg;
      logic       lane_we;
      logic [7:0] lane_wdata;

      assign lane_we    = clr_wr | (acc_wr & be_i[gi]);
      assign lane_wdata = clr_wr ? 8'h00 : wdata_i[8*gi +: 8];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          lane_mem[mem_addr] <= lane_wdata;
        end
        if (acc) begin
          rd_byte_reg <= lane_mem[mem_addr];
        end
      end

      assign old_word[8*gi +: 8] = rd_byte_reg;
      assign data1[8*gi +: 8] = zero1_reg ? 8'h00 :
                                (merge1_reg & be1_reg[gi]) ? wdata1_reg[8*gi +: 8] :
                                rd_byte_reg;
    end
  endgenerate

  // Response side-band captured with the array read so later clears cannot disturb it
  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid1_reg <= 1'b0;
      zero1_reg  <= 1'b1;
      merge1_reg <= 1'b0;
      be1_reg    <= '0;
      wdata1_reg <= '0;
    end else begin
      valid1_reg <= acc;
      if (acc) begin
        zero1_reg  <= ~in_range;
        merge1_reg <= we_i & (WRITE_FIRST != 0);
        be1_reg    <= be_i;
        wdata1_reg <= wdata_i;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic                  rvalid2_reg;
      logic [DATA_WIDTH-1:0] rdata2_reg;
      always_ff @(posedge clk) begin
        if (rst_i) begin
          rvalid2_reg <= 1'b0;
          rdata2_reg  <= '0;
        end else begin
          rvalid2_reg <= valid1_reg;
          if (valid1_reg) begin
            rdata2_reg <= data1;
          end
        end
      end
      assign rvalid_o = rvalid2_reg;
      assign rdata_o  = rdata2_reg;
    end else begin : g_lat1
      logic unused_old_word;
      assign unused_old_word = ^old_word;
      assign rvalid_o = valid1_reg;
      assign rdata_o  = data1;
    end
  endgenerate

endmodule
